// File: rtl/nbody_pkg.sv
// Shared constants for the n-body step sequencer: FSM encodings, pipe latencies
// and the minimum sweep length that keeps velocity write-back ahead of the next read.
package nbody_pkg;

  localparam int MULT_TIME    = 11;
  localparam int ADD_TIME     = 20;
  localparam int INVSQRT_TIME = 30;
  localparam int RD_TIME      = 1;
  // dx/dy subtract, squares, sum, softening add, invsqrt, r^-3 and scale multiplies
  localparam int ACCL_TIME    = 3 * ADD_TIME + 3 * MULT_TIME + INVSQRT_TIME;

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_ACCEL       = 3'd1;
  localparam logic [2:0] S_ACCEL_DRAIN = 3'd2;
  localparam logic [2:0] S_POS         = 3'd3;
  localparam logic [2:0] S_POS_DRAIN   = 3'd4;
  localparam logic [2:0] S_DONE        = 3'd5;

  function automatic int calc_min_sweep(input int add_lat, input int rd_lat);
    return add_lat + rd_lat + 1;
  endfunction

endpackage

// File: rtl/nbody_step_sequencer_if.sv
// Control/status and issue-address bundle between the step sequencer, the bus
// wrapper and the floating-point datapath.
interface nbody_step_sequencer_if #(
  parameter int BAW = 9,
  parameter int SW  = 16
) ();
  logic           i_go;
  logic [BAW:0]   i_num_bodies;
  logic [SW-1:0]  i_num_steps;
  logic           i_done_ack;
  logic           o_busy;
  logic           o_done;
  logic [SW-1:0]  o_step_count;
  logic           o_first_step;
  logic           o_pair_valid;
  logic           o_pair_self;
  logic [BAW-1:0] o_pair_i;
  logic [BAW-1:0] o_pair_j;
  logic           o_vel_rd_valid;
  logic [BAW-1:0] o_vel_rd_addr;
  logic           o_vel_wr_valid;
  logic [BAW-1:0] o_vel_wr_addr;
  logic           o_pos_rd_valid;
  logic [BAW-1:0] o_pos_rd_addr;
  logic           o_pos_wr_valid;
  logic [BAW-1:0] o_pos_wr_addr;

  modport slave (
    input  i_go, i_num_bodies, i_num_steps, i_done_ack,
    output o_busy, o_done, o_step_count, o_first_step,
    output o_pair_valid, o_pair_self, o_pair_i, o_pair_j,
    output o_vel_rd_valid, o_vel_rd_addr, o_vel_wr_valid, o_vel_wr_addr,
    output o_pos_rd_valid, o_pos_rd_addr, o_pos_wr_valid, o_pos_wr_addr
  );

  modport master (
    output i_go, i_num_bodies, i_num_steps, i_done_ack,
    input  o_busy, o_done, o_step_count, o_first_step,
    input  o_pair_valid, o_pair_self, o_pair_i, o_pair_j,
    input  o_vel_rd_valid, o_vel_rd_addr, o_vel_wr_valid, o_vel_wr_addr,
    input  o_pos_rd_valid, o_pos_rd_addr, o_pos_wr_valid, o_pos_wr_addr
  );
endinterface

// File: rtl/nbody_valid_pipe.sv
// Fixed-depth {valid, addr} delay line mirroring a datapath pipe; o_pending counts
// valid entries still to be emitted after the one currently presented.
module nbody_valid_pipe #(
  parameter int DEPTH = 1,
  parameter int AW    = 9
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_flush,
  input  logic                         i_valid,
  input  logic [AW-1:0]                i_addr,
  output logic                         o_valid,
  output logic [AW-1:0]                o_addr,
  output logic [$clog2(DEPTH+1)-1:0]   o_pending
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          r_vld  [DEPTH];
  logic [AW-1:0] r_addr [DEPTH];
  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || i_flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_vld[k]  <= 1'b0;
        r_addr[k] <= '0;
      end
      r_count <= '0;
    end else begin
      r_vld[0]  <= i_valid;
      r_addr[0] <= i_addr;
      for (int k = 1; k < DEPTH; k++) begin
        r_vld[k]  <= r_vld[k-1];
        r_addr[k] <= r_addr[k-1];
      end
      r_count <= r_count + CW'(i_valid) - CW'(r_vld[DEPTH-1]);
    end
  end

  assign o_valid   = r_vld[DEPTH-1];
  assign o_addr    = r_addr[DEPTH-1];
  assign o_pending = r_count - CW'(r_vld[DEPTH-1]);

endmodule

// File: rtl/nbody_step_sequencer.sv
// Timestep scheduler: (i,j) pair issue, delayed velocity/position addressing, done handshake.
// Optional macro NBODY_SEQ_ABORT_EN: dropping go while busy aborts the run back to IDLE.
module nbody_step_sequencer
  import nbody_pkg::*;
#(
  parameter int BODIES          = 512,
  parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
  parameter int STEP_WIDTH      = 16,
  parameter int ACCL_LATENCY    = ACCL_TIME,
  parameter int ADD_LATENCY     = ADD_TIME,
  parameter int RD_LATENCY      = RD_TIME
) (
  input logic                   clk,
  input logic                   rst_n,
  nbody_step_sequencer_if.slave bus
);
  localparam int BAW       = BODY_ADDR_WIDTH;
  localparam int CW        = BAW + 1;
  localparam int MIN_SWEEP = calc_min_sweep(ADD_LATENCY, RD_LATENCY);
  localparam int VWR_DEPTH = RD_LATENCY + ACCL_LATENCY + ADD_LATENCY;
  localparam int PWR_DEPTH = RD_LATENCY + ADD_LATENCY;

  logic [2:0]            r_state;
  logic [CW-1:0]         r_nb, r_len, r_i, r_j, r_k;
  logic [STEP_WIDTH-1:0] r_ns, r_step_count;
  logic                  r_first_step;

  logic           w_busy, w_abort, w_issue_valid, w_pos_valid, w_last_slot;
  logic [BAW-1:0] w_pair_i, w_pair_j, w_pos_addr;
  logic [$clog2(ACCL_LATENCY+1)-1:0] w_vrd_pending;
  logic [$clog2(VWR_DEPTH+1)-1:0]    w_vwr_pending;
  logic [$clog2(PWR_DEPTH+1)-1:0]    w_pwr_pending;

  assign w_busy = (r_state != S_IDLE) && (r_state != S_DONE);

`ifdef NBODY_SEQ_ABORT_EN
  assign w_abort = w_busy && !bus.i_go;
`else
  assign w_abort = 1'b0;
`endif

  // Slots past the body count are bubbles that pad short sweeps out to MIN_SWEEP
  assign w_issue_valid = (r_state == S_ACCEL) && (r_i < r_nb);
  assign w_pair_i      = w_issue_valid ? r_i[BAW-1:0] : '0;
  assign w_pair_j      = w_issue_valid ? r_j[BAW-1:0] : '0;
  assign w_pos_valid   = (r_state == S_POS);
  assign w_pos_addr    = w_pos_valid ? r_k[BAW-1:0] : '0;
  assign w_last_slot   = (r_j == r_nb - CW'(1)) && (r_i == r_len - CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_nb         <= '0;
      r_len        <= '0;
      r_i          <= '0;
      r_j          <= '0;
      r_k          <= '0;
      r_ns         <= '0;
      r_step_count <= '0;
      r_first_step <= 1'b0;
    end else if (w_abort) begin
      r_state      <= S_IDLE;
      r_i          <= '0;
      r_j          <= '0;
      r_k          <= '0;
      r_first_step <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.i_go) begin
          r_nb         <= bus.i_num_bodies;
          r_ns         <= bus.i_num_steps;
          r_len        <= (bus.i_num_bodies > CW'(MIN_SWEEP)) ? bus.i_num_bodies : CW'(MIN_SWEEP);
          r_step_count <= '0;
          r_first_step <= 1'b1;
          r_i          <= '0;
          r_j          <= '0;
          r_k          <= '0;
          r_state      <= (bus.i_num_bodies == '0 || bus.i_num_steps == '0) ? S_DONE : S_ACCEL;
        end
        S_ACCEL: begin
          if (w_last_slot) begin
            r_i     <= '0;
            r_j     <= '0;
            r_state <= S_ACCEL_DRAIN;
          end else if (r_i == r_len - CW'(1)) begin
            r_i <= '0;
            r_j <= r_j + CW'(1);
          end else begin
            r_i <= r_i + CW'(1);
          end
        end
        S_ACCEL_DRAIN: if (w_vrd_pending == '0 && w_vwr_pending == '0) begin
          r_k     <= '0;
          r_state <= S_POS;
        end
        S_POS: begin
          if (r_k == r_nb - CW'(1)) begin
            r_k     <= '0;
            r_state <= S_POS_DRAIN;
          end else begin
            r_k <= r_k + CW'(1);
          end
        end
        S_POS_DRAIN: if (w_pwr_pending == '0) begin
          r_step_count <= r_step_count + STEP_WIDTH'(1);
          r_first_step <= 1'b0;
          r_state      <= (r_step_count + STEP_WIDTH'(1) == r_ns) ? S_DONE : S_ACCEL;
        end
        S_DONE: if (bus.i_done_ack) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  nbody_valid_pipe #(.DEPTH(ACCL_LATENCY), .AW(BAW)) u_vel_rd (
    .clk(clk), .rst_n(rst_n), .i_flush(w_abort),
    .i_valid(w_issue_valid), .i_addr(w_pair_i),
    .o_valid(bus.o_vel_rd_valid), .o_addr(bus.o_vel_rd_addr), .o_pending(w_vrd_pending)
  );

  nbody_valid_pipe #(.DEPTH(VWR_DEPTH), .AW(BAW)) u_vel_wr (
    .clk(clk), .rst_n(rst_n), .i_flush(w_abort),
    .i_valid(w_issue_valid), .i_addr(w_pair_i),
    .o_valid(bus.o_vel_wr_valid), .o_addr(bus.o_vel_wr_addr), .o_pending(w_vwr_pending)
  );

  nbody_valid_pipe #(.DEPTH(PWR_DEPTH), .AW(BAW)) u_pos_wr (
    .clk(clk), .rst_n(rst_n), .i_flush(w_abort),
    .i_valid(w_pos_valid), .i_addr(w_pos_addr),
    .o_valid(bus.o_pos_wr_valid), .o_addr(bus.o_pos_wr_addr), .o_pending(w_pwr_pending)
  );

  assign bus.o_busy         = w_busy;
  assign bus.o_done         = (r_state == S_DONE);
  assign bus.o_step_count   = r_step_count;
  assign bus.o_first_step   = r_first_step;
  assign bus.o_pair_valid   = w_issue_valid;
  assign bus.o_pair_i       = w_pair_i;
  assign bus.o_pair_j       = w_pair_j;
  assign bus.o_pair_self    = w_issue_valid && (r_i == r_j);
  assign bus.o_pos_rd_valid = w_pos_valid;
  assign bus.o_pos_rd_addr  = w_pos_addr;

endmodule

// File: tb/tb_nbody_step_sequencer.sv
// Scoreboard bench for nbody_step_sequencer: stimulus queues expected issue events,
// a negedge monitor pops and compares them as the sequencer emits valids.
module tb_nbody_step_sequencer;
  localparam int BAW     = 9;
  localparam int SW      = 16;
  localparam int VRD_DLY = 123;  // ACCL_LATENCY
  localparam int VWR_DLY = 144;  // RD + ACCL + ADD
  localparam int PWR_DLY = 21;   // RD + ADD
  localparam int MINS    = 22;   // ADD + RD + 1

  typedef struct {
    int cyc;
    int a;
    int b;
    bit self_f;
    bit fs;
    int rel;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nbody_step_sequencer_if #(.BAW(BAW), .SW(SW)) bus ();

  nbody_step_sequencer #(
    .BODIES(512), .BODY_ADDR_WIDTH(BAW), .STEP_WIDTH(SW),
    .ACCL_LATENCY(123), .ADD_LATENCY(20), .RD_LATENCY(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  n_checks = 0;
  int  n_fail = 0;
  ev_t q_pair[$], q_vrd[$], q_vwr[$], q_prd[$], q_pwr[$];
  int  rd_cnt[512], wr_cnt[512];
  int  pair_base = 0, pos_base = 0, last_pwr_cyc = -100;
  int  n_valid_seen = 0, n_wr_seen = 0;
  ev_t m_e;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_pending(input string nm, input int qsize);
    n_checks++;
    if (qsize == 0) begin
      n_fail++;
      $display("FAIL %s: valid seen with no expected entry (cycle %0d)", nm, cyc);
    end
  endtask

  function automatic ev_t mk(input int c, input int a, input int b, input bit s, input bit f, input int r);
    ev_t e;
    e.cyc = c; e.a = a; e.b = b; e.self_f = s; e.fs = f; e.rel = r;
    return e;
  endfunction

  // Monitor: one compare group per emitted valid
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_pair_valid) begin
        n_valid_seen++;
        chk_pending("pair_pending", q_pair.size());
        if (q_pair.size() != 0) begin
          m_e = q_pair.pop_front();
          if (m_e.rel == 0) begin
            pair_base = cyc;
            if (m_e.cyc >= 0) chk("pair_first_cycle", cyc, m_e.cyc);
          end
          chk("pair_slot", cyc - pair_base, m_e.rel);
          chk("pair_i", int'(bus.o_pair_i), m_e.a);
          chk("pair_j", int'(bus.o_pair_j), m_e.b);
          chk("pair_self", int'(bus.o_pair_self), int'(m_e.self_f));
          chk("pair_first_step", int'(bus.o_first_step), int'(m_e.fs));
          q_vrd.push_back(mk(cyc + VRD_DLY, m_e.a, 0, 1'b0, 1'b0, 0));
          q_vwr.push_back(mk(cyc + VWR_DLY, m_e.a, 0, 1'b0, 1'b0, 0));
        end
      end
      if (bus.o_vel_rd_valid) begin
        n_valid_seen++;
        chk_pending("vel_rd_pending", q_vrd.size());
        if (q_vrd.size() != 0) begin
          m_e = q_vrd.pop_front();
          chk("vel_rd_cycle", cyc, m_e.cyc);
          chk("vel_rd_addr", int'(bus.o_vel_rd_addr), m_e.a);
        end
        chk("vel_wr_before_rd", wr_cnt[bus.o_vel_rd_addr], rd_cnt[bus.o_vel_rd_addr]);
        rd_cnt[bus.o_vel_rd_addr]++;
      end
      if (bus.o_vel_wr_valid) begin
        n_valid_seen++;
        n_wr_seen++;
        chk_pending("vel_wr_pending", q_vwr.size());
        if (q_vwr.size() != 0) begin
          m_e = q_vwr.pop_front();
          chk("vel_wr_cycle", cyc, m_e.cyc);
          chk("vel_wr_addr", int'(bus.o_vel_wr_addr), m_e.a);
        end
        wr_cnt[bus.o_vel_wr_addr]++;
      end
      if (bus.o_pos_rd_valid) begin
        n_valid_seen++;
        chk_pending("pos_rd_pending", q_prd.size());
        if (q_prd.size() != 0) begin
          m_e = q_prd.pop_front();
          if (m_e.rel == 0) pos_base = cyc;
          chk("pos_rd_slot", cyc - pos_base, m_e.rel);
          chk("pos_rd_addr", int'(bus.o_pos_rd_addr), m_e.a);
          chk("pos_first_step", int'(bus.o_first_step), int'(m_e.fs));
          q_pwr.push_back(mk(cyc + PWR_DLY, m_e.a, 0, 1'b0, 1'b0, 0));
        end
      end
      if (bus.o_pos_wr_valid) begin
        n_valid_seen++;
        n_wr_seen++;
        chk_pending("pos_wr_pending", q_pwr.size());
        if (q_pwr.size() != 0) begin
          m_e = q_pwr.pop_front();
          chk("pos_wr_cycle", cyc, m_e.cyc);
          chk("pos_wr_addr", int'(bus.o_pos_wr_addr), m_e.a);
        end
        last_pwr_cyc = cyc;
      end
    end
  end

  // Expected pair/pos issue order for a whole run; t0 is the first pair cycle
  task automatic push_run(input int nb, input int ns, input int t0);
    int len;
    len = (nb > MINS) ? nb : MINS;
    for (int s = 0; s < ns; s++) begin
      for (int j = 0; j < nb; j++)
        for (int i = 0; i < nb; i++)
          q_pair.push_back(mk((s == 0) ? t0 + j * len + i : -1, i, j, i == j, s == 0, j * len + i));
      for (int k = 0; k < nb; k++)
        q_prd.push_back(mk(-1, k, 0, 1'b0, s == 0, k));
    end
  endtask

  task automatic clear_model();
    q_pair.delete(); q_vrd.delete(); q_vwr.delete(); q_prd.delete(); q_pwr.delete();
    foreach (rd_cnt[k]) begin
      rd_cnt[k] = 0;
      wr_cnt[k] = 0;
    end
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (bus.o_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_seen", int'(ok), 1);
  endtask

  task automatic end_of_run_checks(input int nb, input int ns, input int t);
    if (nb == 0 || ns == 0) chk("done_latency", cyc, t + 1);
    else chk("done_after_pos_wr", cyc, last_pwr_cyc + 1);
    chk("step_count", int'(bus.o_step_count), (nb == 0 || ns == 0) ? 0 : ns);
    chk("busy_in_done", int'(bus.o_busy), 0);
    chk("queues_drained", q_pair.size() + q_vrd.size() + q_vwr.size() + q_prd.size() + q_pwr.size(), 0);
    $display("run nb=%0d ns=%0d go@%0d done@%0d step_count=%0d", nb, ns, t, cyc, bus.o_step_count);
  endtask

  // go is held until done so that abort-enabled builds also complete normally
  task automatic do_run(input int nb, input int ns);
    bit ok;
    int t, seen0;
    @(negedge clk);
    bus.i_num_bodies = (BAW + 1)'(nb);
    bus.i_num_steps  = SW'(ns);
    bus.i_go = 1'b1;
    t = cyc;
    seen0 = n_valid_seen;
    if (nb > 0 && ns > 0) push_run(nb, ns, t + 1);
    wait_done(20000, ok);
    if (ok) end_of_run_checks(nb, ns, t);
    if (nb == 0 || ns == 0) chk("no_valids_empty_run", n_valid_seen - seen0, 0);
    bus.i_go = 1'b0;
  endtask

  task automatic ack_after(input int dly);
    int held;
    held = 0;
    for (int n = 0; n < dly; n++) begin
      @(negedge clk);
      if (bus.o_done) held++;
    end
    chk("done_held", held, dly);
    bus.i_done_ack = 1'b1;
    @(negedge clk);
    chk("done_fall", int'(bus.o_done), 0);
    bus.i_done_ack = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, int'(bus.o_busy), 0);
    chk({tag, "_done"}, int'(bus.o_done), 0);
    chk({tag, "_step_count"}, int'(bus.o_step_count), 0);
    chk({tag, "_first_step"}, int'(bus.o_first_step), 0);
    chk({tag, "_pair"}, int'({bus.o_pair_valid, bus.o_pair_self, bus.o_pair_i, bus.o_pair_j}), 0);
    chk({tag, "_vel_rd"}, int'({bus.o_vel_rd_valid, bus.o_vel_rd_addr}), 0);
    chk({tag, "_vel_wr"}, int'({bus.o_vel_wr_valid, bus.o_vel_wr_addr}), 0);
    chk({tag, "_pos_rd"}, int'({bus.o_pos_rd_valid, bus.o_pos_rd_addr}), 0);
    chk({tag, "_pos_wr"}, int'({bus.o_pos_wr_valid, bus.o_pos_wr_addr}), 0);
  endtask

  initial begin
    bit ok;
    int t;
    bus.i_go = 1'b0;
    bus.i_num_bodies = '0;
    bus.i_num_steps = '0;
    bus.i_done_ack = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    do_run(3, 1);
    ack_after(3);
    do_run(0, 4);
    ack_after(1);
    do_run(5, 0);
    ack_after(1);
    do_run(30, 2);
    ack_after(1);

    // go held high: mid-run ack ignored, done held until ack, then IDLE restarts
    @(negedge clk);
    bus.i_num_bodies = 10'd3;
    bus.i_num_steps = 16'd1;
    bus.i_go = 1'b1;
    t = cyc;
    push_run(3, 1, t + 1);
    repeat (20) @(negedge clk);
    bus.i_done_ack = 1'b1;
    @(negedge clk);
    bus.i_done_ack = 1'b0;
    chk("ack_mid_run_busy", int'(bus.o_busy), 1);
    wait_done(2000, ok);
    if (ok) end_of_run_checks(3, 1, t);
    t = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.o_done) t++;
    end
    chk("done_held_go_high", t, 10);
    push_run(3, 1, cyc + 2);
    t = cyc + 1;
    bus.i_done_ack = 1'b1;
    @(negedge clk);
    bus.i_done_ack = 1'b0;
    chk("done_fall_restart", int'(bus.o_done), 0);
    wait_done(2000, ok);
    if (ok) end_of_run_checks(3, 1, t);
    bus.i_go = 1'b0;
    ack_after(1);

    // asynchronous reset in the middle of ACCEL
    @(negedge clk);
    bus.i_num_bodies = 10'd8;
    bus.i_num_steps = 16'd1;
    bus.i_go = 1'b1;
    t = cyc;
    push_run(8, 1, t + 1);
    repeat (155) @(negedge clk);
    chk("pre_reset_pair_valid", int'(bus.o_pair_valid), 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrun_reset");
    $display("reset asserted mid-ACCEL at cycle %0d", cyc);
    bus.i_go = 1'b0;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;

`ifdef NBODY_SEQ_ABORT_EN
    // dropping go mid-POS aborts the run
    @(negedge clk);
    bus.i_num_bodies = 10'd3;
    bus.i_num_steps = 16'd1;
    bus.i_go = 1'b1;
    push_run(3, 1, cyc + 1);
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (bus.o_pos_rd_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("abort_reached_pos", int'(ok), 1);
    bus.i_go = 1'b0;
    t = n_wr_seen;
    @(negedge clk);
    chk("abort_busy", int'(bus.o_busy), 0);
    chk("abort_done", int'(bus.o_done), 0);
    chk("abort_first_step", int'(bus.o_first_step), 0);
    repeat (200) @(negedge clk);
    chk("abort_no_writes", n_wr_seen - t, 0);
    chk("abort_done_later", int'(bus.o_done), 0);
    $display("abort in POS checked at cycle %0d", cyc);
    clear_model();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
